// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : core_sequencer
// Description : Multi-cycle sequencer for the R.O.E core. Owns the program
//               counter and instruction register, and steps every 9-bit
//               instruction through FETCH, DECODE, EXEC, optional MEM and WB.
//               Turns decoder enables into single-cycle strobes and runs the
//               data-memory request/acknowledge handshake with a timeout.
// Ports       : clk, reset_n          - clock, async active-low reset
//               start, start_addr     - (re)start execution at start_addr
//               imem_addr, imem_rdata - instruction fetch (comb. read)
//               instr                 - instruction register to decoder
//               reg_write, mem_read,
//               mem_write             - decoder enables for instr
//               branch_taken,
//               branch_target         - next-PC selection, sampled in WB
//               rf_we                 - register-file write strobe
//               dmem_req, dmem_we,
//               dmem_ack, ld_en       - data-memory handshake
//               busy, done, fault     - run status
//               instr_count           - retired instructions (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module core_sequencer #(
    parameter int          PC_W        = 10,
    parameter int          MEM_TIMEOUT = 16,
    parameter logic [8:0]  HALT_INSTR  = 9'h1FF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [PC_W-1:0] start_addr,
    output logic [PC_W-1:0] imem_addr,
    input  logic [8:0]      imem_rdata,
    output logic [8:0]      instr,
    input  logic            reg_write,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic            rf_we,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic            ld_en,
    output logic            busy,
    output logic            done,
    output logic            fault,
    output logic [15:0]     instr_count
);

    // One spare bit so the counter can hold MEM_TIMEOUT itself and the
    // increment constant below never needs a zero-width replication.
    localparam int                   c_WAIT_W   = $clog2(MEM_TIMEOUT + 1) + 1;
    localparam logic [c_WAIT_W-1:0]  c_TIMEOUT  = c_WAIT_W'(MEM_TIMEOUT);
    localparam logic [c_WAIT_W-1:0]  c_WAIT_ONE = {{(c_WAIT_W-1){1'b0}}, 1'b1};
    localparam logic [PC_W-1:0]      c_PC_ONE   = {{(PC_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALTED = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PC_W-1:0]     r_pc;
    logic [8:0]          r_instr;
    logic [15:0]         r_count;
    logic [c_WAIT_W-1:0] r_wait;

    logic                w_idle_like;
    logic                w_start_ok;
    logic                w_is_halt;
    logic                w_timeout;
    logic                w_retire;
    logic [c_WAIT_W-1:0] w_wait_inc;

    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_HALTED) || (r_state == S_FAULT);
    assign w_start_ok  = start && w_idle_like;
    assign w_is_halt   = (r_instr == HALT_INSTR);
    assign w_wait_inc  = r_wait + c_WAIT_ONE;
    // This MEM cycle is the MEM_TIMEOUT-th one without an acknowledge.
    assign w_timeout   = (w_wait_inc >= c_TIMEOUT);
    // A halt retires in DECODE; every other instruction retires in WB.
    assign w_retire    = ((r_state == S_DECODE) && w_is_halt) || (r_state == S_WB);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode (outputs gated by the registered state)
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        rf_we       = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        ld_en       = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        fault       = 1'b0;

        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_state_nxt = S_FETCH;
            end
            S_HALTED: begin
                busy = 1'b0;
                done = 1'b1;
                if (start) w_state_nxt = S_FETCH;
            end
            S_FAULT: begin
                busy  = 1'b0;
                fault = 1'b1;
                if (start) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                w_state_nxt = w_is_halt ? S_HALTED : S_EXEC;
            end
            S_EXEC: begin
                if (mem_read && mem_write) begin
                    w_state_nxt = S_FAULT;
                end else if (mem_read || mem_write) begin
                    w_state_nxt = S_MEM;
                end else begin
                    w_state_nxt = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = mem_write;
                ld_en    = dmem_ack && mem_read;
                // An acknowledge on the timeout cycle still completes the access.
                if (dmem_ack) begin
                    w_state_nxt = S_WB;
                end else if (w_timeout) begin
                    w_state_nxt = S_FAULT;
                end
            end
            S_WB: begin
                rf_we       = reg_write;
                w_state_nxt = S_FETCH;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // PC, instruction register, retire counter, MEM wait counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc    <= '0;
            r_instr <= '0;
            r_count <= '0;
            r_wait  <= '0;
        end else begin
            if (w_start_ok) begin
                r_pc <= start_addr;
            end else if (r_state == S_WB) begin
                // PC + 1 wraps naturally at the top of the address space.
                r_pc <= branch_taken ? branch_target : (r_pc + c_PC_ONE);
            end

            if (r_state == S_FETCH) begin
                r_instr <= imem_rdata;
            end

            if (w_start_ok) begin
                r_count <= '0;
            end else if (w_retire && (r_count != 16'hFFFF)) begin
                r_count <= r_count + 16'd1;
            end

            if (r_state == S_EXEC) begin
                r_wait <= '0;
            end else if ((r_state == S_MEM) && !dmem_ack) begin
                r_wait <= w_wait_inc;
            end
        end
    end

    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_count = r_count;

endmodule
`default_nettype wire
